// File: rtl/filter_scheduler_if.sv
// Event port of the filter scheduler: one output transition per valid/ready handshake.
interface filter_scheduler_if #(
    parameter int CH_W = 2
);
    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_ch;
    logic            evt_rise;

    modport master (
        output evt_valid,
        output evt_ch,
        output evt_rise,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        input  evt_rise,
        output evt_ready
    );
endinterface

// File: rtl/filter_scheduler.sv
// Time-multiplexed glitch filter: one shared history/JK decision unit scans N_CH
// synchronized channels round-robin and reports each output transition as an event.
module filter_scheduler #(
    parameter int N_CH  = 4,
    parameter int DEPTH = 3,
    parameter int DIV   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [N_CH-1:0]        sig_in,
    output logic [N_CH-1:0]        sig_out,
    output logic                   busy,
    filter_scheduler_if.master     evt
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
    localparam logic [CH_W-1:0] IDX_LAST   = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PW-1:0]     r_presc;
    logic [PW-1:0]     w_presc_nxt;
    logic [CH_W-1:0]   r_idx;
    logic [CH_W-1:0]   w_idx_nxt;

    logic [N_CH-1:0]   r_sync1;
    logic [N_CH-1:0]   r_sync2;
    logic [N_CH-1:0]   r_sig_out;
    logic [DEPTH-1:0]  r_hist [N_CH];

    logic              r_evt_valid;
    logic [CH_W-1:0]   r_evt_ch;
    logic              r_evt_rise;

    logic              w_slot_free;
    logic              w_process;
    logic              w_s_cur;
    logic              w_out_cur;
    logic [DEPTH-1:0]  w_hist_cur;
    logic [DEPTH-1:0]  w_new_h;
    logic              w_j;
    logic              w_k;
    logic              w_post;

    assign w_slot_free = ~r_evt_valid | evt.evt_ready;

    // Shared decision unit looks at the channel currently pointed to by the scan index.
    assign w_s_cur    = r_sync2[r_idx];
    assign w_out_cur  = r_sig_out[r_idx];
    assign w_hist_cur = r_hist[r_idx];
    assign w_new_h    = DEPTH'({w_hist_cur, w_s_cur});
    assign w_j        = &w_new_h;
    assign w_k        = ~|w_new_h;
    assign w_post     = w_process & ((w_j & ~w_out_cur) | (w_k & w_out_cur));

    // FSM state, prescaler and scan index registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic; dropping enable abandons the channel in progress.
    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_idx_nxt   = r_idx;
        w_process   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_WAIT;
                    w_presc_nxt = '0;
                    w_idx_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_presc == PRESC_LAST) begin
                    w_state_nxt = ST_SCAN;
                    w_presc_nxt = '0;
                    w_idx_nxt   = '0;
                end else begin
                    w_presc_nxt = r_presc + PW'(1);
                end
            end
            ST_SCAN: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_slot_free) begin
                    w_process = 1'b1;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = ST_WAIT;
                        w_presc_nxt = '0;
                    end else begin
                        w_idx_nxt = r_idx + CH_W'(1);
                    end
                end else begin
                    w_state_nxt = ST_SCAN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_presc_nxt = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Synchronizers, per-channel history and filtered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sig_out <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            if (w_process) begin
                r_hist[r_idx] <= w_new_h;
            end
            if (w_post) begin
                r_sig_out[r_idx] <= ~w_out_cur;
            end
        end
    end

    // Single-entry event slot; a post on the accepting edge reloads without a gap.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_evt_rise  <= 1'b0;
        end else if (w_post) begin
            r_evt_valid <= 1'b1;
            r_evt_ch    <= r_idx;
            r_evt_rise  <= ~w_out_cur;
        end else if (r_evt_valid && evt.evt_ready) begin
            r_evt_valid <= 1'b0;
        end
    end

    assign sig_out       = r_sig_out;
    assign busy          = (r_state == ST_SCAN);
    assign evt.evt_valid = r_evt_valid;
    assign evt.evt_ch    = r_evt_ch;
    assign evt.evt_rise  = r_evt_rise;
endmodule
